// File: rtl/auto_machine_pkg.sv
// -----------------------------------------------------------------------------
// auto_machine_pkg
// Shared types and helpers for the auto_machine_v2 washing-machine sequencer.
//   state_e     : 4-bit state encoding, also exported on state_o for debug
//   mode_e      : wash mode selected on the panel (3 behaves as normal)
//   ERR_*       : fault codes reported on err_code
//   timer_load  : phase-timer load value (N-1) for a timed state
//   is_locked / is_timed / is_pausable : state classification helpers
// Prewash encodings exist in every build. Without AUTO_MACHINE_PREWASH_EN the
// FSM never enters them.
// -----------------------------------------------------------------------------
package auto_machine_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOCK       = 4'd1,
        ST_FILL       = 4'd2,
        ST_SOAP       = 4'd3,
        ST_WASH       = 4'd4,
        ST_DRAIN      = 4'd5,
        ST_RINSE_FILL = 4'd6,
        ST_RINSE      = 4'd7,
        ST_SPIN       = 4'd8,
        ST_DONE       = 4'd9,
        ST_PAUSED     = 4'd10,
        ST_ERROR      = 4'd11,
        ST_PRE_FILL   = 4'd12,
        ST_PRE_WASH   = 4'd13,
        ST_PRE_DRAIN  = 4'd14
    } state_e;

    typedef enum logic [1:0] {
        MODE_QUICK      = 2'd0,
        MODE_NORMAL     = 2'd1,
        MODE_HEAVY      = 2'd2,
        MODE_NORMAL_ALT = 2'd3
    } mode_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FILL  = 2'd1;
    localparam logic [1:0] ERR_DRAIN = 2'd2;
    localparam logic [1:0] ERR_DOOR  = 2'd3;

    // A timed phase lasting N cycles loads N-1 and leaves when the count is 0.
    function automatic int timer_load(state_e st, mode_e m, int wash, int rinse,
                                      int spin, int prewash);
        int n;
        case (st)
            ST_WASH: begin
                case (m)
                    MODE_QUICK: n = wash >> 1;
                    MODE_HEAVY: n = wash << 1;
                    default:    n = wash;
                endcase
            end
            ST_RINSE:    n = rinse;
            ST_SPIN:     n = spin;
            ST_PRE_WASH: n = prewash;
            default:     n = 1;
        endcase
        return n - 1;
    endfunction

    function automatic logic is_locked(state_e st);
        return st inside {ST_LOCK, ST_FILL, ST_SOAP, ST_WASH, ST_DRAIN,
                          ST_RINSE_FILL, ST_RINSE, ST_SPIN, ST_PAUSED,
                          ST_PRE_FILL, ST_PRE_WASH, ST_PRE_DRAIN};
    endfunction

    function automatic logic is_timed(state_e st);
        return st inside {ST_WASH, ST_RINSE, ST_SPIN, ST_PRE_WASH};
    endfunction

    function automatic logic is_pausable(state_e st);
        return st inside {ST_WASH, ST_RINSE, ST_SPIN};
    endfunction

endpackage

// File: rtl/auto_machine_v2_wash_timer.sv
// -----------------------------------------------------------------------------
// wash_timer
// Loadable down-counter for the timed wash phases.
//   clk, reset_n : clock, asynchronous active-low reset
//   load_i       : load load_val_i (takes priority over counting)
//   load_val_i   : value loaded, N-1 for an N-cycle phase
//   freeze_i     : hold the current count (pause, untimed states, phase exit)
//   zero_o       : count has reached 0
// The counter stops at 0 and never wraps.
// -----------------------------------------------------------------------------
module wash_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         freeze_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (!freeze_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/auto_machine_v2.sv
// -----------------------------------------------------------------------------
// auto_machine_v2
// Washing-machine sequencer for one drum: lock, fill, soap, timed wash,
// drain, N rinse passes, spin, done. Includes pause/resume of timed phases,
// fill/drain watchdogs and a door-interlock fault.
// Optional feature: define AUTO_MACHINE_PREWASH_EN to add the prewash input
// and the PRE_FILL -> PRE_WASH -> PRE_DRAIN phases between LOCK and FILL.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   door_close, start, pause       panel/sensor levels
//   err_clr                        fault acknowledge
//   mode[1:0]                      0 quick, 1 normal, 2 heavy, 3 normal
//   rinse_req[RW-1:0]              requested rinse passes, clamped to MAX_RINSE
//   filled, detergent_added, drained  process sensors
//   prewash                        (AUTO_MACHINE_PREWASH_EN only) run prewash
//   door_lock, motor_on, fill_valve_on, drain_valve_on  actuators
//   soap_wash, water_wash, done, error                  phase indicators
//   err_code[1:0]                  0 none, 1 fill timeout, 2 drain timeout, 3 door
//   state_o[3:0]                   current state (debug)
// All outputs are decoded from the registered state only.
// -----------------------------------------------------------------------------
module auto_machine_v2
    import auto_machine_pkg::*;
#(
    parameter int TIMER_W        = 16,
    parameter int WASH_CYCLES    = 600,
    parameter int RINSE_CYCLES   = 300,
    parameter int SPIN_CYCLES    = 200,
    parameter int PREWASH_CYCLES = 200,
    parameter int FILL_TIMEOUT   = 1000,
    parameter int DRAIN_TIMEOUT  = 1000,
    parameter int MAX_RINSE      = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             door_close,
    input  logic                             start,
    input  logic                             pause,
    input  logic                             err_clr,
    input  logic [1:0]                       mode,
    input  logic [$clog2(MAX_RINSE+1)-1:0]   rinse_req,
    input  logic                             filled,
    input  logic                             detergent_added,
    input  logic                             drained,
`ifdef AUTO_MACHINE_PREWASH_EN
    input  logic                             prewash,
`endif
    output logic                             door_lock,
    output logic                             motor_on,
    output logic                             fill_valve_on,
    output logic                             drain_valve_on,
    output logic                             soap_wash,
    output logic                             water_wash,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic [3:0]                       state_o
);

    localparam int RW = $clog2(MAX_RINSE + 1);
    localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);

    state_e             state_q, state_d;
    state_e             saved_q, saved_d;
    mode_e              mode_q, mode_d;
    logic [RW-1:0]      rinse_left_q, rinse_left_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [TIMER_W-1:0] wd_q, wd_d;
`ifdef AUTO_MACHINE_PREWASH_EN
    logic               prewash_q, prewash_d;
`endif

    logic               wd_active, wd_sensor, wd_expired;
    logic [TIMER_W-1:0] wd_last;
    logic [1:0]         wd_code;

    logic               tmr_load, tmr_freeze, tmr_zero;
    logic [TIMER_W-1:0] tmr_load_val;

    // ---------------------------------------------------------------- watchdog
    // Counts cycles spent waiting for a level sensor; expiry is only declared
    // when the sensor is still absent, so a sensor arriving on the last
    // allowed cycle wins.
    always_comb begin
        wd_active = 1'b0;
        wd_sensor = 1'b0;
        wd_last   = FILL_LAST;
        wd_code   = ERR_FILL;
        case (state_q)
            ST_FILL, ST_RINSE_FILL, ST_PRE_FILL: begin
                wd_active = 1'b1;
                wd_sensor = filled;
            end
            ST_DRAIN, ST_PRE_DRAIN: begin
                wd_active = 1'b1;
                wd_sensor = drained;
                wd_last   = DRAIN_LAST;
                wd_code   = ERR_DRAIN;
            end
            default: ;
        endcase
        wd_expired = wd_active && !wd_sensor && (wd_q == wd_last);
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        mode_d       = mode_q;
        rinse_left_d = rinse_left_q;
        err_code_d   = err_code_q;
`ifdef AUTO_MACHINE_PREWASH_EN
        prewash_d    = prewash_q;
`endif
        // Fault and pause checks ahead of the per-state transitions give the
        // priority door fault > watchdog > pause > normal progress.
        if (is_locked(state_q) && !door_close) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_DOOR;
        end else if (wd_expired) begin
            state_d    = ST_ERROR;
            err_code_d = wd_code;
        end else if (is_pausable(state_q) && pause) begin
            saved_d = state_q;
            state_d = ST_PAUSED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && door_close) begin
                        state_d      = ST_LOCK;
                        mode_d       = mode_e'(mode);
                        rinse_left_d = (rinse_req > RW'(MAX_RINSE)) ? RW'(MAX_RINSE) : rinse_req;
`ifdef AUTO_MACHINE_PREWASH_EN
                        prewash_d    = prewash;
`endif
                    end
                end
`ifdef AUTO_MACHINE_PREWASH_EN
                ST_LOCK:       state_d = prewash_q ? ST_PRE_FILL : ST_FILL;
                ST_PRE_FILL:   if (filled)   state_d = ST_PRE_WASH;
                ST_PRE_WASH:   if (tmr_zero) state_d = ST_PRE_DRAIN;
                ST_PRE_DRAIN:  if (drained)  state_d = ST_FILL;
`else
                ST_LOCK:       state_d = ST_FILL;
`endif
                ST_FILL:       if (filled)          state_d = ST_SOAP;
                ST_SOAP:       if (detergent_added) state_d = ST_WASH;
                ST_WASH:       if (tmr_zero)        state_d = ST_DRAIN;
                ST_DRAIN: begin
                    if (drained) begin
                        state_d = (rinse_left_q != '0) ? ST_RINSE_FILL : ST_SPIN;
                    end
                end
                ST_RINSE_FILL: if (filled) state_d = ST_RINSE;
                ST_RINSE: begin
                    if (tmr_zero) begin
                        state_d      = ST_DRAIN;
                        rinse_left_d = rinse_left_q - 1'b1;
                    end
                end
                ST_SPIN:       if (tmr_zero)    state_d = ST_DONE;
                ST_DONE:       if (!door_close) state_d = ST_IDLE;
                ST_PAUSED:     if (!pause)      state_d = saved_q;
                ST_ERROR: begin
                    if (err_clr) begin
                        state_d    = ST_IDLE;
                        err_code_d = ERR_NONE;
                    end
                end
                // Reserved encodings recover to IDLE.
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ phase timer
    // Load only on a fresh entry into a timed state; returning from PAUSED
    // keeps the remaining count. The count moves only while the FSM stays in
    // a timed state, so the cycle that enters PAUSED does not consume a tick.
    always_comb begin
        tmr_load     = (state_d != state_q) && is_timed(state_d) && (state_q != ST_PAUSED);
        tmr_freeze   = !(is_timed(state_q) && (state_d == state_q));
        tmr_load_val = TIMER_W'(timer_load(state_d, mode_q, WASH_CYCLES, RINSE_CYCLES,
                                           SPIN_CYCLES, PREWASH_CYCLES));
    end

    wash_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .freeze_i   (tmr_freeze),
        .zero_o     (tmr_zero)
    );

    // Watchdog restarts on every state change and outside watched states.
    assign wd_d = (!wd_active || (state_d != state_q)) ? '0 : wd_q + 1'b1;

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            saved_q      <= ST_IDLE;
            mode_q       <= MODE_NORMAL;
            rinse_left_q <= '0;
            err_code_q   <= ERR_NONE;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            mode_q       <= mode_d;
            rinse_left_q <= rinse_left_d;
            err_code_q   <= err_code_d;
            wd_q         <= wd_d;
        end
    end

`ifdef AUTO_MACHINE_PREWASH_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prewash_q <= 1'b0;
        end else begin
            prewash_q <= prewash_d;
        end
    end
`endif

    // ------------------------------------------------------------ Moore outputs
    always_comb begin
        door_lock      = is_locked(state_q);
        motor_on       = 1'b0;
        fill_valve_on  = 1'b0;
        drain_valve_on = 1'b0;
        soap_wash      = 1'b0;
        water_wash     = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (state_q)
            ST_FILL, ST_RINSE_FILL, ST_PRE_FILL: fill_valve_on = 1'b1;
            ST_DRAIN, ST_PRE_DRAIN:              drain_valve_on = 1'b1;
            ST_WASH: begin
                motor_on  = 1'b1;
                soap_wash = 1'b1;
            end
            ST_RINSE, ST_PRE_WASH: begin
                motor_on   = 1'b1;
                water_wash = 1'b1;
            end
            ST_SPIN: begin
                motor_on       = 1'b1;
                drain_valve_on = 1'b1;
            end
            ST_DONE: done = 1'b1;
            ST_ERROR: begin
                error          = 1'b1;
                drain_valve_on = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_code = err_code_q;
    assign state_o  = state_q;

endmodule
